// File: rtl/mm3_stage_sequencer_if.sv
// Host-side and child-side handshake bundle for the mm3 stage sequencer.
// The sequencer uses the slave view; the host (or bench) uses the master
// view.
// The master drives ap_start, the child ready/done lines and the readback
// select.
interface mm3_stage_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = 2
);
    logic                  ap_start;
    logic                  ap_done;
    logic                  ap_ready;
    logic                  ap_idle;
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] stage_done;
    logic [SEL_W-1:0]      rd_sel;
    logic [CNT_W-1:0]      rd_cycles;
    logic                  err_sticky;

    modport master (
        output ap_start, stage_ready, stage_done, rd_sel,
        input  ap_done, ap_ready, ap_idle, stage_start, rd_cycles, err_sticky
    );

    modport slave (
        input  ap_start, stage_ready, stage_done, rd_sel,
        output ap_done, ap_ready, ap_idle, stage_start, rd_cycles, err_sticky
    );
endinterface

// File: rtl/mm3_stage_sequencer.sv
// Top-level control FSM for the mm3 kernel.
// It launches the three matrix-product loop modules one after another:
// E=A*B, then F=C*D, then G=E*F.
// Each child is driven through its start/ready/done handshake.
// The start-to-done latency of every stage is kept for readback.
// Protocol violations by the children are flagged in a sticky error bit.
module mm3_stage_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = 2
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    mm3_stage_sequencer_if.slave        bus
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      cur, cur_nxt;
    logic [NUM_STAGES-1:0] cur_mask;
    logic                  active;
    logic                  launch_entry;
    logic                  stage_finish;

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      lat [NUM_STAGES];
    logic [CNT_W-1:0]      rd_val;

    logic [NUM_STAGES-1:0] pending, pending_nxt;
    logic [NUM_STAGES-1:0] stray_done, stray_ready;
    logic                  proto_err;
    logic                  err_q;

    logic [NUM_STAGES-1:0] start_q;
    logic                  done_q;
    logic                  idle_q;

    assign cur_mask = NUM_STAGES'(1) << cur;
    assign active   = (state == LAUNCH) || (state == WAIT);

    // Next-state and stage-index selection; a done seen while still launching counts as completion.
    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur;
        launch_entry = 1'b0;
        stage_finish = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ap_start) begin
                    cur_nxt      = '0;
                    state_nxt    = LAUNCH;
                    launch_entry = 1'b1;
                end
            end
            LAUNCH: begin
                if (|(bus.stage_done & cur_mask)) begin
                    stage_finish = 1'b1;
                end else if (|(bus.stage_ready & cur_mask)) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (|(bus.stage_done & cur_mask)) begin
                    stage_finish = 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (stage_finish) begin
            if (cur == LAST) begin
                state_nxt = FIN;
            end else begin
                cur_nxt      = cur + 1'b1;
                state_nxt    = LAUNCH;
                launch_entry = 1'b1;
            end
        end
    end

    // Classify child handshakes that do not belong to the stage currently in flight.
    // Children orphaned by a reset may still deliver one stale response; the
    // pending mask excuses that response.
    always_comb begin
        stray_done  = bus.stage_done  & ~(active ? cur_mask : '0) & ~pending;
        stray_ready = bus.stage_ready & ~((state == LAUNCH) ? cur_mask : '0) & ~pending;
        proto_err   = (|stray_done) || (|stray_ready);
        pending_nxt = pending & ~bus.stage_done;
        if (launch_entry) begin
            pending_nxt = pending_nxt & ~(NUM_STAGES'(1) << cur_nxt);
        end
    end

    // State register and current stage index.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            cur   <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
        end
    end

    // Remember which child was cut off by a reset so its late response is not flagged.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            pending <= active ? cur_mask : '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Inclusive per-stage latency counter, restarted at 1 on every launch and saturating.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt <= '0;
        end else if (launch_entry) begin
            cnt <= CNT_W'(1);
        end else if (active && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture the counter into the finishing stage's latency slot.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                lat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (stage_finish && (cur == IDX_W'(i))) begin
                    lat[i] <= cnt;
                end
            end
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            err_q <= 1'b0;
        end else if (proto_err) begin
            err_q <= 1'b1;
        end
    end

    // Registered handshake outputs, decoded from the upcoming state so they align with it.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            start_q <= '0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            start_q <= (state_nxt == LAUNCH) ? (NUM_STAGES'(1) << cur_nxt) : '0;
            done_q  <= (state_nxt == FIN);
            idle_q  <= (state_nxt == IDLE);
        end
    end

    // Latency readback mux; out-of-range selects read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_val = lat[i];
            end
        end
    end

    assign bus.stage_start = start_q;
    assign bus.ap_done     = done_q;
    assign bus.ap_ready    = done_q;
    assign bus.ap_idle     = idle_q;
    assign bus.rd_cycles   = rd_val;
    assign bus.err_sticky  = err_q;

endmodule

// File: tb/tb_mm3_stage_sequencer.sv
// Directed bench for mm3_stage_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
// A second instance with 4-bit counters exercises saturation.
module tb_mm3_stage_sequencer;
    logic ap_clk = 1'b0;
    logic ap_rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 ap_clk = ~ap_clk;

    // Free-running cycle index used to measure distances between events.
    always @(posedge ap_clk) cyc++;

    mm3_stage_sequencer_if #(.NUM_STAGES(3), .CNT_W(32), .SEL_W(2)) bus ();
    mm3_stage_sequencer_if #(.NUM_STAGES(3), .CNT_W(4),  .SEL_W(2)) sbus ();

    mm3_stage_sequencer #(.NUM_STAGES(3), .CNT_W(32), .SEL_W(2)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    mm3_stage_sequencer #(.NUM_STAGES(3), .CNT_W(4), .SEL_W(2)) dut_sat (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (sbus)
    );

    // Wait for stage i to launch, then play a child that raises ready at
    // offset rdy_at and done at offset done_at (offsets from the launch
    // cycle). An optional spurious done pattern is injected at spur_at.
    // Returns positioned on the cycle after done, with inputs cleared.
    task automatic run_stage(input int i, input int rdy_at, input int done_at,
                             input int spur_at, input logic [2:0] spur_mask,
                             output int start_cyc, output int waited);
        logic bad;
        waited = 0;
        while (bus.stage_start[i] !== 1'b1 && waited < 200) begin
            @(negedge ap_clk);
            waited++;
        end
        checks++;
        if (bus.stage_start[i] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stage%0d_launch: stage_start=%b, required bit %0d set", i, bus.stage_start, i);
        end
        start_cyc = cyc;
        bad = 1'b0;
        for (int t = 0; t <= done_at; t++) begin
            if (t > 0) @(negedge ap_clk);
            if (!(bus.stage_start === 3'b000 || bus.stage_start === (3'b001 << i))) bad = 1'b1;
            if (bus.ap_done !== 1'b0) bad = 1'b1;
            bus.stage_ready = (t == rdy_at)  ? (3'b001 << i) : 3'b000;
            bus.stage_done  = (t == done_at) ? (3'b001 << i) : 3'b000;
            if (t == spur_at) bus.stage_done = bus.stage_done | spur_mask;
        end
        @(negedge ap_clk);
        bus.stage_ready = 3'b000;
        bus.stage_done  = 3'b000;
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL stage%0d_onehot: stage_start/ap_done misbehaved during stage, required only bit %0d or 0", i, i);
        end
    endtask

    // Issue one ap_start pulse; returns on the cycle stage 0 is expected to launch.
    task automatic start_run();
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        checks++;
        if (bus.ap_idle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_idle: ap_idle=%b, required 0", bus.ap_idle);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        repeat (3) @(negedge ap_clk);
        checks++;
        if (bus.ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL rst_idle: got %b required 1", bus.ap_idle); end
        checks++;
        if (bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_done: got done=%b ready=%b required 0/0", bus.ap_done, bus.ap_ready);
        end
        checks++;
        if (bus.stage_start !== 3'b000) begin errors++; $display("[TB] FAIL rst_start: got %b required 000", bus.stage_start); end
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b required 0", bus.err_sticky); end
        checks++;
        if (bus.rd_cycles !== 32'd0) begin errors++; $display("[TB] FAIL rst_lat: got %0d required 0", bus.rd_cycles); end
        ap_rst = 1'b0;
    endtask

    task automatic test_nominal();
        int s0, s1, s2, w0, w1, w2;
        int exp_lat [3];
        exp_lat = '{10, 20, 30};
        start_run();
        run_stage(0, 1, 9,  -1, 3'b000, s0, w0);
        run_stage(1, 1, 19, -1, 3'b000, s1, w1);
        run_stage(2, 1, 29, -1, 3'b000, s2, w2);
        checks++;
        if (w0 != 0 || w1 != 0 || w2 != 0) begin
            errors++; $display("[TB] FAIL nom_order: launch waits %0d/%0d/%0d, required 0/0/0", w0, w1, w2);
        end
        checks++;
        if (bus.ap_done !== 1'b1 || bus.ap_ready !== 1'b1 || bus.ap_idle !== 1'b0) begin
            errors++; $display("[TB] FAIL nom_done: done=%b ready=%b idle=%b, required 1/1/0", bus.ap_done, bus.ap_ready, bus.ap_idle);
        end
        for (int k = 0; k < 3; k++) begin
            bus.rd_sel = 2'(k);
            #1;
            checks++;
            if (bus.rd_cycles !== 32'(exp_lat[k])) begin
                errors++; $display("[TB] FAIL nom_lat%0d: got %0d required %0d", k, bus.rd_cycles, exp_lat[k]);
            end
        end
        @(negedge ap_clk);
        checks++;
        if (bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b1) begin
            errors++; $display("[TB] FAIL nom_after: done=%b idle=%b, required 0/1", bus.ap_done, bus.ap_idle);
        end
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL nom_err: got %b required 0", bus.err_sticky); end
    endtask

    // Ready and done in the launch cycle: first start at S, ap_done at S+3.
    task automatic test_same_cycle();
        int s0, s1, s2, w;
        start_run();
        run_stage(0, 0, 0, -1, 3'b000, s0, w);
        run_stage(1, 0, 0, -1, 3'b000, s1, w);
        run_stage(2, 0, 0, -1, 3'b000, s2, w);
        checks++;
        if (bus.ap_done !== 1'b1 || (cyc - s0) != 3) begin
            errors++; $display("[TB] FAIL fast_done: ap_done=%b at +%0d cycles, required 1 at +3", bus.ap_done, cyc - s0);
        end
        for (int k = 0; k < 3; k++) begin
            bus.rd_sel = 2'(k);
            #1;
            checks++;
            if (bus.rd_cycles !== 32'd1) begin
                errors++; $display("[TB] FAIL fast_lat%0d: got %0d required 1", k, bus.rd_cycles);
            end
        end
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL fast_err: got %b required 0", bus.err_sticky); end
        @(negedge ap_clk);
    endtask

    task automatic test_spurious();
        int s, w2, w;
        int exp_lat [3];
        exp_lat = '{5, 3, 3};
        start_run();
        run_stage(0, 1, 4, 3, 3'b100, s, w);
        checks++;
        if (bus.err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL spur_err: got %b required 1", bus.err_sticky); end
        run_stage(1, 1, 2, -1, 3'b000, s, w);
        run_stage(2, 1, 2, -1, 3'b000, s, w2);
        checks++;
        if (w2 != 0 || bus.ap_done !== 1'b1) begin
            errors++; $display("[TB] FAIL spur_seq: stage2 wait %0d ap_done=%b, required 0/1", w2, bus.ap_done);
        end
        for (int k = 0; k < 3; k++) begin
            bus.rd_sel = 2'(k);
            #1;
            checks++;
            if (bus.rd_cycles !== 32'(exp_lat[k])) begin
                errors++; $display("[TB] FAIL spur_lat%0d: got %0d required %0d", k, bus.rd_cycles, exp_lat[k]);
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic test_reset_mid_run();
        int s, w;
        int exp_lat [3];
        exp_lat = '{3, 4, 5};
        start_run();
        run_stage(0, 1, 2, -1, 3'b000, s, w);
        @(negedge ap_clk);
        bus.stage_ready = 3'b010;
        @(negedge ap_clk);
        bus.stage_ready = 3'b000;
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        checks++;
        if (bus.ap_idle !== 1'b1 || bus.stage_start !== 3'b000 || bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_rst_out: idle=%b start=%b done=%b ready=%b, required 1/000/0/0",
                               bus.ap_idle, bus.stage_start, bus.ap_done, bus.ap_ready);
        end
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_err: got %b required 0", bus.err_sticky); end
        for (int k = 0; k < 3; k++) begin
            bus.rd_sel = 2'(k);
            #1;
            checks++;
            if (bus.rd_cycles !== 32'd0) begin
                errors++; $display("[TB] FAIL mid_rst_lat%0d: got %0d required 0", k, bus.rd_cycles);
            end
        end
        @(negedge ap_clk);
        bus.stage_done = 3'b010;
        @(negedge ap_clk);
        bus.stage_done = 3'b000;
        @(negedge ap_clk);
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL stale_done_err: got %b required 0", bus.err_sticky); end
        start_run();
        run_stage(0, 1, 2, -1, 3'b000, s, w);
        run_stage(1, 1, 3, -1, 3'b000, s, w);
        run_stage(2, 1, 4, -1, 3'b000, s, w);
        checks++;
        if (bus.ap_done !== 1'b1) begin errors++; $display("[TB] FAIL rerun_done: got %b required 1", bus.ap_done); end
        for (int k = 0; k < 3; k++) begin
            bus.rd_sel = 2'(k);
            #1;
            checks++;
            if (bus.rd_cycles !== 32'(exp_lat[k])) begin
                errors++; $display("[TB] FAIL rerun_lat%0d: got %0d required %0d", k, bus.rd_cycles, exp_lat[k]);
            end
        end
        checks++;
        if (bus.err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL rerun_err: got %b required 0", bus.err_sticky); end
        @(negedge ap_clk);
    endtask

    task automatic test_back_to_back();
        int s, w, d1;
        int exp_lat [3];
        exp_lat = '{6, 7, 1};
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        @(negedge ap_clk);
        run_stage(0, 1, 2, -1, 3'b000, s, w);
        run_stage(1, 1, 3, -1, 3'b000, s, w);
        run_stage(2, 1, 4, -1, 3'b000, s, w);
        d1 = cyc;
        checks++;
        if (bus.ap_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %b required 1", bus.ap_done); end
        @(negedge ap_clk);
        checks++;
        if (bus.ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle: got %b required 1", bus.ap_idle); end
        @(negedge ap_clk);
        checks++;
        if (bus.stage_start !== 3'b001 || (cyc - d1) != 2) begin
            errors++; $display("[TB] FAIL b2b_restart: stage_start=%b at ap_done+%0d, required 001 at +2", bus.stage_start, cyc - d1);
        end
        bus.ap_start = 1'b0;
        run_stage(0, 1, 5, -1, 3'b000, s, w);
        run_stage(1, 2, 6, -1, 3'b000, s, w);
        run_stage(2, 0, 0, -1, 3'b000, s, w);
        checks++;
        if (bus.ap_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %b required 1", bus.ap_done); end
        for (int k = 0; k < 3; k++) begin
            bus.rd_sel = 2'(k);
            #1;
            checks++;
            if (bus.rd_cycles !== 32'(exp_lat[k])) begin
                errors++; $display("[TB] FAIL b2b_lat%0d: got %0d required %0d", k, bus.rd_cycles, exp_lat[k]);
            end
        end
        bus.rd_sel = 2'd3;
        #1;
        checks++;
        if (bus.rd_cycles !== 32'd0) begin errors++; $display("[TB] FAIL sel3_main: got %0d required 0", bus.rd_cycles); end
        @(negedge ap_clk);
    endtask

    // 4-bit counters: a 20-cycle stage 0 must read back as 15.
    task automatic test_saturation();
        @(negedge ap_clk);
        sbus.ap_start = 1'b1;
        @(negedge ap_clk);
        sbus.ap_start = 1'b0;
        checks++;
        if (sbus.stage_start !== 3'b001) begin errors++; $display("[TB] FAIL sat_launch: got %b required 001", sbus.stage_start); end
        for (int t = 0; t <= 19; t++) begin
            if (t > 0) @(negedge ap_clk);
            sbus.stage_ready = (t == 1)  ? 3'b001 : 3'b000;
            sbus.stage_done  = (t == 19) ? 3'b001 : 3'b000;
        end
        @(negedge ap_clk);
        sbus.stage_ready = 3'b010;
        sbus.stage_done  = 3'b010;
        @(negedge ap_clk);
        sbus.stage_ready = 3'b100;
        sbus.stage_done  = 3'b100;
        @(negedge ap_clk);
        sbus.stage_ready = 3'b000;
        sbus.stage_done  = 3'b000;
        checks++;
        if (sbus.ap_done !== 1'b1) begin errors++; $display("[TB] FAIL sat_done: got %b required 1", sbus.ap_done); end
        sbus.rd_sel = 2'd0;
        #1;
        checks++;
        if (sbus.rd_cycles !== 4'd15) begin errors++; $display("[TB] FAIL sat_lat0: got %0d required 15", sbus.rd_cycles); end
        sbus.rd_sel = 2'd1;
        #1;
        checks++;
        if (sbus.rd_cycles !== 4'd1) begin errors++; $display("[TB] FAIL sat_lat1: got %0d required 1", sbus.rd_cycles); end
        sbus.rd_sel = 2'd3;
        #1;
        checks++;
        if (sbus.rd_cycles !== 4'd0) begin errors++; $display("[TB] FAIL sat_sel3: got %0d required 0", sbus.rd_cycles); end
        checks++;
        if (sbus.err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL sat_err: got %b required 0", sbus.err_sticky); end
        @(negedge ap_clk);
    endtask

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ap_rst           = 1'b1;
        bus.ap_start     = 1'b0;
        bus.stage_ready  = 3'b000;
        bus.stage_done   = 3'b000;
        bus.rd_sel       = 2'd0;
        sbus.ap_start    = 1'b0;
        sbus.stage_ready = 3'b000;
        sbus.stage_done  = 3'b000;
        sbus.rd_sel      = 2'd0;
        test_reset();
        test_nominal();
        test_same_cycle();
        test_spurious();
        test_reset_mid_run();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
